// File: rtl/lcd_pclk_gen.sv
// Pixel clock generator: divides clk by a ratio looked up from the panel ID.
// Ratio and run/stop changes take effect only at a period boundary, so pulses are never shortened.
module lcd_pclk_gen #(
  parameter int          DIV_W = 8,
  parameter logic [15:0] ID_0  = 16'h4342,
  parameter logic [15:0] ID_1  = 16'h7084,
  parameter logic [15:0] ID_2  = 16'h7016,
  parameter logic [15:0] ID_3  = 16'h4384,
  parameter logic [15:0] ID_4  = 16'h1018,
  parameter int          DIV_0 = 4,
  parameter int          DIV_1 = 8,
  parameter int          DIV_2 = 2,
  parameter int          DIV_3 = 4,
  parameter int          DIV_4 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] lcd_id,
  output logic        lcd_pclk,
  output logic        pclk_rise,
  output logic        pclk_fall,
  output logic        locked
);

  typedef enum logic {ST_STOPPED, ST_RUN} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_divCur;
  logic [DIV_W-1:0] r_cnt;

  logic [DIV_W-1:0] w_divNew;
  logic [DIV_W:0]   w_hi;
  logic [DIV_W:0]   w_cntNext;
  logic             w_wrap;
  logic             w_start;

  // A ratio below 2 cannot form a high and a low phase, so it means stop.
  function automatic logic [DIV_W-1:0] divOf(input int d);
    return (d < 2) ? '0 : DIV_W'(d);
  endfunction

  always_comb begin
    w_divNew = '0;
    if (lcd_id == ID_0)      w_divNew = divOf(DIV_0);
    else if (lcd_id == ID_1) w_divNew = divOf(DIV_1);
    else if (lcd_id == ID_2) w_divNew = divOf(DIV_2);
    else if (lcd_id == ID_3) w_divNew = divOf(DIV_3);
    else if (lcd_id == ID_4) w_divNew = divOf(DIV_4);
  end

  assign w_hi      = ({1'b0, r_divCur} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign w_cntNext = {1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign w_wrap    = (r_cnt == r_divCur - {{(DIV_W-1){1'b0}}, 1'b1});
  assign w_start   = en && (w_divNew != '0);

  // High phase is ceil(N/2) cycles, low phase floor(N/2); the ratio is re-sampled only on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_STOPPED;
      r_divCur  <= '0;
      r_cnt     <= '0;
      lcd_pclk  <= 1'b0;
      pclk_rise <= 1'b0;
      pclk_fall <= 1'b0;
      locked    <= 1'b0;
    end else begin
      pclk_rise <= 1'b0;
      pclk_fall <= 1'b0;
      locked    <= (r_divCur != '0) && en && (w_divNew == r_divCur);
      case (r_state)
        ST_STOPPED: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_divCur  <= w_divNew;
            r_cnt     <= '0;
            lcd_pclk  <= 1'b1;
            pclk_rise <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_wrap) begin
            r_cnt     <= w_cntNext[DIV_W-1:0];
            lcd_pclk  <= (w_cntNext < w_hi);
            pclk_fall <= (w_cntNext == w_hi);
          end else if (w_start) begin
            r_divCur  <= w_divNew;
            r_cnt     <= '0;
            lcd_pclk  <= 1'b1;
            pclk_rise <= 1'b1;
          end else begin
            r_state   <= ST_STOPPED;
            r_divCur  <= '0;
            r_cnt     <= '0;
            lcd_pclk  <= 1'b0;
          end
        end
        default: r_state <= ST_STOPPED;
      endcase
    end
  end

endmodule

// File: doc/lcd_pclk_gen.md
LCD_PCLK_GEN -- requirements
Module: lcd_pclk_gen

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DIV_W, default 8, width of divide ratios and phase counter.
REQ-003 Parameters ID_0..ID_4, defaults 16'h4342, 16'h7084, 16'h7016, 16'h4384, 16'h1018: panel IDs in the lookup table.
REQ-004 Parameters DIV_0..DIV_4, defaults 4, 8, 2, 4, 4: clk cycles per pclk period for the matching ID_n (clk nominal 100 MHz).
REQ-005 Port clk  input  1  system clock.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port en  input  1  run request; low stops pclk at the next period boundary.
REQ-008 Port lcd_id  input  16  panel ID selecting the divide ratio.
REQ-009 Port lcd_pclk  output  1  registered pixel clock.
REQ-010 Port pclk_rise  output  1  one-clk strobe, high in the first clk cycle of each pclk-high phase.
REQ-011 Port pclk_fall  output  1  one-clk strobe, high in the first clk cycle of each pclk-low phase.
REQ-012 Port locked  output  1  high when running with no ratio change pending.

Function
REQ-013 Lookup: div_new = DIV_n for the lowest n with lcd_id == ID_n; no match, or DIV_n < 2, gives div_new = 0 (stop).
REQ-014 Internal state: div_cur (DIV_W bits, 0 = stopped) and cnt (DIV_W bits, phase 0..div_cur-1).
REQ-015 Define HI = (div_cur+1)>>1, computed in DIV_W+1 bits: pclk is high for ceil(N/2) and low for floor(N/2) cycles of each N-cycle period.
REQ-016 STOPPED state (div_cur == 0): cnt = 0, lcd_pclk = 0, strobes = 0, locked = 0.
REQ-017 STOPPED to RUN: on the first edge where en = 1 and div_new != 0, load div_cur <= div_new, cnt <= 0, lcd_pclk <= 1, pclk_rise <= 1.
REQ-018 RUN, mid-period edge (cnt != div_cur-1): set cnt <= cnt+1, lcd_pclk <= (cnt+1 < HI), and pclk_fall <= (cnt+1 == HI).
REQ-019 RUN, wrap edge (cnt == div_cur-1) with en = 1 and div_new != 0: load div_cur <= div_new, cnt <= 0, lcd_pclk <= 1, pclk_rise <= 1.
REQ-020 RUN, wrap edge with en = 0 or div_new == 0: go to STOPPED; lcd_pclk <= 0.
REQ-021 A change of lcd_id or en mid-period SHALL NOT alter the current period; it takes effect only at the wrap edge, so pulses are never shortened (glitch-free switching).
REQ-022 pclk_rise and pclk_fall SHALL each be high for exactly one clk cycle and never high in the same cycle.
REQ-023 locked = 1 iff div_cur != 0, en = 1 and div_new == div_cur; registered, updated every edge.
REQ-024 Latency: lcd_pclk rises on the first edge after en/lcd_id become valid in STOPPED.
REQ-025 lcd_id glitches lasting less than one period and reverting before the wrap edge SHALL have no effect.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-027 While rst = 1 at an edge, the block SHALL set div_cur = 0, cnt = 0, lcd_pclk = 0, pclk_rise = 0, pclk_fall = 0 and locked = 0; rst overrides every other condition.
REQ-028 Reset asserted mid-period SHALL force lcd_pclk low on that edge; after release the block SHALL follow REQ-017.

Verification
REQ-029 lcd_id = 16'h4342, en = 1 after reset: lcd_pclk pattern 1,1,0,0 repeating; pclk_rise every 4 clk; pclk_fall 2 clk after each rise; locked = 1 from the second cycle.
REQ-030 Set all DIV_n = 5 and lcd_id = ID_0: pattern 1,1,1,0,0; period 5 clk; exactly one rise and one fall per period.
REQ-031 Running with div 8 (16'h7084), switch lcd_id to 16'h7016 at cnt = 2: locked drops next edge; the current 8-cycle period completes; the next period is 1,0; no pulse shorter than 1 clk high or low.
REQ-032 Running with div 4, set lcd_id = 16'hFFFF (unknown): the current period finishes, then lcd_pclk = 0 and locked = 0 indefinitely; restoring 16'h4342 restarts on the next edge with pclk_rise = 1.
REQ-033 Running with div 8, deassert en at cnt = 1: the period completes, then the block stops; re-assert en: restart per REQ-017.
REQ-034 Assert rst at cnt = 1 while lcd_pclk = 1: all outputs are 0 on that edge; one cycle after release lcd_pclk = 1 with pclk_rise = 1.
